imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the CPU fetch path reads.
- Accepts a byte stream over a valid/ready handshake: 16-bit big-endian word count, then that many 32-bit big-endian instruction words.
- Writes each assembled word into the instruction-memory write port.
- Holds the CPU stalled until the load completes.

Parameters:
- ADDR_W, 8: instruction-memory word-address width; capacity 2**ADDR_W words.
- BASE_ADDR, 0: word address of the first loaded instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load.
- byte_data  in  8  stream byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  loader can accept a byte.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  ADDR_W  instruction-memory word address.
- wr_data  out  32  instruction word.
- cpu_hold  out  1  stalls the CPU; high except in DONE.
- done  out  1  load completed successfully.
- error  out  1  load aborted.
- words_loaded  out  16  words written in the current or last load.

Behaviour:
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR; plus CSUM when the optional feature is compiled in.
- Reset values: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, words_loaded=0.
- Transfer: a byte is consumed only on a cycle where byte_valid and byte_ready are both high.
  - byte_ready=1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in all other states.
  - byte_valid is ignored while byte_ready=0.
- IDLE/DONE/ERROR + start: go to LEN_HI; clear done, error, words_loaded and the byte index; set cpu_hold=1.
- start in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- LEN_HI: consumed byte becomes count[15:8]; go to LEN_LO.
- LEN_LO: consumed byte becomes count[7:0]. Next state:
  - count > 2**ADDR_W: ERROR.
  - count == 0: DONE (CSUM if compiled in).
  - otherwise: DATA.
- DATA byte packing: byte index 0..3 maps to wr_data[31:24], [23:16], [15:8], [7:0].
- Write timing:
  - On the cycle the 4th byte is consumed, the write is registered.
  - On the next cycle: wr_en=1 for exactly one cycle, wr_addr = BASE_ADDR + words_loaded (pre-increment), wr_data = full word.
  - words_loaded increments in that same cycle.
- Back-to-back bytes are accepted every cycle; write latency is a fixed 1 cycle after the 4th byte.
- After the final word is consumed, go to DONE (CSUM if compiled in).
  - The last wr_en is still issued in the first DONE/CSUM cycle.
  - cpu_hold falls in the cycle after that wr_en, so the CPU never fetches a partially written image.
- wr_addr width: BASE_ADDR + index is truncated to ADDR_W, so addresses wrap modulo 2**ADDR_W. count == 2**ADDR_W is legal and fills the memory exactly.
- DONE: done=1, cpu_hold=0 (after the pending write). Stays until a new start or reset.
- ERROR: error=1, cpu_hold=1, no further writes. Stays until a new start or reset.
- Reset mid-load: returns to IDLE next cycle. Any partial word and any pending write are discarded; wr_en=0 on the cycle after rst_n is sampled low.
- After reset with no load, cpu_hold stays 1.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Defined:
  - After the last data byte (or after LEN_LO when count==0), enter CSUM and accept one more byte.
  - The expected value is the XOR of every byte consumed in LEN_HI, LEN_LO and DATA.
  - Match: DONE. Mismatch: ERROR.
  - Memory writes are not rolled back on mismatch.
- Undefined: the CSUM state and the XOR register do not exist; DATA/LEN_LO go directly to DONE.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants: IDLE=0, LEN_HI=1, LEN_LO=2, DATA=3, CSUM=4, DONE=5, ERROR=6;
  - INSTR_W=32;
  - default IMEM ADDR_W.
- One natural sub-module: imem_word_packer, covering the byte index counter, the 32-bit shift/assemble register and the registered wr_en/wr_data stage. The FSM stays in imem_loader.

Test Plan:
- Stream 00 02 | 20 08 00 05 | 01 09 50 20, byte_valid continuously high → writes (addr 0, 0x20080005), then (addr 1, 0x01095020), each wr_en one cycle wide; done=1, words_loaded=2, cpu_hold falls 1 cycle after the last wr_en.
- Stream 00 00 → no wr_en; done=1 two cycles after the LEN_LO byte; cpu_hold=0.
- ADDR_W=4, count bytes 00 11 (17 words) → error=1, byte_ready=0, no writes; a new start then recovers to LEN_HI.
- Byte_valid toggling 1/0 each cycle during a 1-word load → the word is still assembled correctly; no byte is consumed while byte_ready=0.
- rst_n low after the 2nd data byte → state IDLE, no wr_en, cpu_hold=1, words_loaded=0; a restarted load writes to BASE_ADDR.
- IMEM_LOADER_CSUM_EN, stream 00 01 AA BB CC DD, then trailer 0x01 (XOR of 00 01 AA BB CC DD) → done. Same stream with trailer 0x00 → error, but the word 0xAABBCCDD is still written.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | cpu_pkg: shared loader state encoding and instruction-memory constants.
// | Revision: 1.0
// +----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } load_state_e;

  localparam int INSTR_W     = 32;
  localparam int IMEM_ADDR_W = 8;
  localparam int COUNT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | imem_word_packer: assembles big-endian bytes into instruction words and
// | issues a one-cycle registered write strobe one cycle after the 4th byte.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module imem_word_packer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               byte_fire_i,
  input  logic [7:0]         byte_data_i,
  output logic               word_done_o,
  output logic               wr_en_o,
  output logic [INSTR_W-1:0] wr_data_o
);

  logic [1:0]         idx_q;
  logic [INSTR_W-9:0] shift_q;
  logic               wr_en_q;
  logic [INSTR_W-1:0] wr_data_q;

  assign word_done_o = byte_fire_i && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= 2'd0;
      shift_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (clear_i) begin
        idx_q <= 2'd0;
      end else if (byte_fire_i) begin
        if (idx_q == 2'd3) begin
          wr_en_q   <= 1'b1;
          wr_data_q <= {shift_q, byte_data_i};
          idx_q     <= 2'd0;
        end else begin
          shift_q <= {shift_q[INSTR_W-17:0], byte_data_i};
          idx_q   <= idx_q + 2'd1;
        end
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | imem_loader: boot-time byte-stream writer for the instruction memory; holds
// | the CPU until the image is complete. Optional trailer XOR check: IMEM_LOADER_CSUM_EN.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] words_loaded
);

  localparam logic [COUNT_W:0]  MAX_WORDS = {{COUNT_W{1'b0}}, 1'b1} << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

`ifdef IMEM_LOADER_CSUM_EN
  localparam load_state_e END_STATE = ST_CSUM;
`else
  localparam load_state_e END_STATE = ST_DONE;
`endif

  load_state_e        state_q;
  load_state_e        state_d;
  logic               byte_ready_q;
  logic               cpu_hold_q;
  logic               done_q;
  logic               error_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] words_loaded_q;

  logic               byte_fire;
  logic               data_fire;
  logic               start_accept;
  logic               word_done;
  logic               last_word;
  logic [COUNT_W-1:0] len_full;

  assign byte_fire    = byte_valid && byte_ready_q;
  assign data_fire    = byte_fire && (state_q == ST_DATA);
  assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));
  assign len_full     = {count_q[COUNT_W-1:8], byte_data};
  assign last_word    = (words_loaded_q == (count_q - COUNT_W'(1)));

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum_q;

  // Running XOR of header and payload bytes; the trailer byte is excluded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= 8'd0;
    end else if (start_accept) begin
      csum_q <= 8'd0;
    end else if (byte_fire && (state_q != ST_CSUM)) begin
      csum_q <= csum_q ^ byte_data;
    end
  end
`endif

  imem_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (start_accept),
    .byte_fire_i (data_fire),
    .byte_data_i (byte_data),
    .word_done_o (word_done),
    .wr_en_o     (wr_en),
    .wr_data_o   (wr_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (byte_fire) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (byte_fire) begin
          if ({1'b0, len_full} > MAX_WORDS) state_d = ST_ERROR;
          else if (len_full == '0)          state_d = END_STATE;
          else                              state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_done && last_word) state_d = END_STATE;
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (byte_fire) state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      byte_ready_q   <= 1'b0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      wr_addr_q      <= '0;
      count_q        <= '0;
      words_loaded_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                      (state_d == ST_DATA)   || (state_d == ST_CSUM);
      if (start_accept) begin
        done_q         <= 1'b0;
        error_q        <= 1'b0;
        cpu_hold_q     <= 1'b1;
        words_loaded_q <= '0;
      end
      if (byte_fire && (state_q == ST_LEN_HI)) count_q[COUNT_W-1:8] <= byte_data;
      if (byte_fire && (state_q == ST_LEN_LO)) count_q[7:0] <= byte_data;
      // Address is latched with the word so it pairs with the delayed strobe.
      if (word_done) begin
        wr_addr_q      <= BASE + words_loaded_q[ADDR_W-1:0];
        words_loaded_q <= words_loaded_q + COUNT_W'(1);
      end
      // Release one cycle into DONE so the final write has already landed.
      if ((state_q == ST_DONE) && !start) begin
        done_q     <= 1'b1;
        cpu_hold_q <= 1'b0;
      end
      if (state_d == ST_ERROR) error_q <= 1'b1;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign wr_addr      = wr_addr_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_imem_loader: randomized self-checking bench for imem_loader (two configs).
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW_A   = 8;
  localparam int BASE_A = 0;
  localparam int AW_B   = 4;
  localparam int BASE_B = 13;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [47:0] wr_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_valid = 1'b0;

  logic            byte_ready_a, wr_en_a, cpu_hold_a, done_a, error_a;
  logic [AW_A-1:0] wr_addr_a;
  logic [31:0]     wr_data_a;
  logic [15:0]     words_loaded_a;
  logic            byte_ready_b, wr_en_b, cpu_hold_b, done_b, error_b;
  logic [AW_B-1:0] wr_addr_b;
  logic [31:0]     wr_data_b;
  logic [15:0]     words_loaded_b;

  imem_loader #(.ADDR_W(AW_A), .BASE_ADDR(BASE_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready_a), .wr_en(wr_en_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .cpu_hold(cpu_hold_a),
    .done(done_a), .error(error_a), .words_loaded(words_loaded_a)
  );

  imem_loader #(.ADDR_W(AW_B), .BASE_ADDR(BASE_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .cpu_hold(cpu_hold_b),
    .done(done_b), .error(error_b), .words_loaded(words_loaded_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  wr_q_t wq_a, wq_b;
  int    wcyc_a[$], wcyc_b[$];
  int    fall_a = -1, fall_b = -1;
  logic  ph_a = 1'b1, ph_b = 1'b1;

  // Observe memory writes and the cpu_hold release away from the active edge.
  always @(negedge clk) begin
    if (wr_en_a === 1'b1) begin
      wq_a.push_back({8'h00, wr_addr_a, wr_data_a});
      wcyc_a.push_back(cyc);
    end
    if (wr_en_b === 1'b1) begin
      wq_b.push_back({12'h000, wr_addr_b, wr_data_b});
      wcyc_b.push_back(cyc);
    end
    if (ph_a && !cpu_hold_a) fall_a = cyc;
    if (ph_b && !cpu_hold_b) fall_b = cyc;
    ph_a = cpu_hold_a;
    ph_b = cpu_hold_b;
  end

  // Reference model: stream layout and expected writes from count and words.
  task automatic build(input int count, input int aw, input int base, input word_q_t w,
                       output byte_q_t s, output wr_q_t e, output bit err);
    s = {};
    e = {};
    err = (count > (1 << aw));
    s.push_back(8'(count >> 8));
    s.push_back(8'(count));
    if (!err) begin
      for (int i = 0; i < count; i++) begin
        for (int k = 3; k >= 0; k--) s.push_back(8'(w[i] >> (8 * k)));
        e.push_back({16'((base + i) % (1 << aw)), w[i]});
      end
`ifdef IMEM_LOADER_CSUM_EN
      begin
        logic [7:0] x;
        x = 8'd0;
        foreach (s[j]) x ^= s[j];
        s.push_back(x);
      end
`endif
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // mode 0: valid always high, 1: toggling, 2: random.
  task automatic drive(input bit sel, input byte_q_t s, input int mode,
                       output int consumed, output int last_fire);
    int  i = 0;
    int  t = 0;
    bit  v, rdy;
    bit  tog = 1'b1;
    last_fire = -1;
    while (i < s.size() && t < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      rdy        = sel ? byte_ready_b : byte_ready_a;
      byte_valid = v;
      byte_data  = v ? s[i] : 8'($urandom);
      @(negedge clk);
      t++;
      if (v && rdy) begin
        i++;
        last_fire = cyc;
      end
    end
    byte_valid = 1'b0;
    consumed = i;
  endtask

  task automatic wait_end(input bit sel, output bit ok);
    int t = 0;
    ok = 1'b0;
    while (t < 200) begin
      if (sel ? (done_b || error_b) : (done_a || error_a)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_load(input bit sel, input byte_q_t s, input int mode,
                          output int consumed, output int last_fire, output bit ok);
    wq_a = {}; wq_b = {}; wcyc_a = {}; wcyc_b = {};
    fall_a = -1; fall_b = -1;
    pulse_start(sel);
    drive(sel, s, mode, consumed, last_fire);
    wait_end(sel, ok);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({byte_ready_a, wr_en_a, cpu_hold_a, done_a, error_a} !== 5'b00100) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00100",
                        {byte_ready_a, wr_en_a, cpu_hold_a, done_a, error_a});
    end
    tests++;
    if ({wr_addr_a, wr_data_a, words_loaded_a} !== '0) begin
      fails++; $display("FAIL reset_data: addr %h data %h words %0d want zeros",
                        wr_addr_a, wr_data_a, words_loaded_a);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if ({cpu_hold_a, cpu_hold_b, byte_ready_a, byte_ready_b, wr_en_a} !== 5'b11000) begin
      fails++; $display("FAIL idle_hold: got %b want 11000",
                        {cpu_hold_a, cpu_hold_b, byte_ready_a, byte_ready_b, wr_en_a});
    end
  endtask

  task automatic test_two_words;
    byte_q_t s;
    wr_q_t   e;
    bit      err, ok;
    int      n, lf;
    word_q_t w;
    w = {32'h20080005, 32'h01095020};
    build(2, AW_A, BASE_A, w, s, e, err);
    run_load(1'b0, s, 0, n, lf, ok);
    tests++;
    if (!ok || n != s.size()) begin
      fails++; $display("FAIL two_words_end: ok %0d consumed %0d want 1 %0d", ok, n, s.size());
    end
    tests++;
    if (wq_a.size() != 2 || wq_a[0] !== 48'h0000_20080005 || wq_a[1] !== 48'h0001_01095020) begin
      fails++; $display("FAIL two_words_writes: got %0d writes first %h want 2 writes", wq_a.size(),
                        (wq_a.size() > 0) ? wq_a[0] : 48'h0);
    end
    tests++;
    if (wcyc_a.size() != 2 || (wcyc_a[1] - wcyc_a[0]) != 4) begin
      fails++; $display("FAIL two_words_spacing: got %0d writes want 2 spaced 4 cycles", wcyc_a.size());
    end
    tests++;
    if ({done_a, error_a, cpu_hold_a} !== 3'b100 || words_loaded_a !== 16'd2) begin
      fails++; $display("FAIL two_words_status: got %b words %0d want 100 words 2",
                        {done_a, error_a, cpu_hold_a}, words_loaded_a);
    end
`ifndef IMEM_LOADER_CSUM_EN
    tests++;
    if (wcyc_a.size() != 2 || fall_a != wcyc_a[1] + 1) begin
      fails++; $display("FAIL two_words_hold: hold fell at %0d want one after last write", fall_a);
    end
`endif
    tests++;
    if (fall_a != lf + 1) begin
      fails++; $display("FAIL two_words_release: hold fell at %0d want %0d", fall_a, lf + 1);
    end
  endtask

  task automatic test_zero_count;
    byte_q_t s;
    wr_q_t   e;
    bit      err, ok;
    int      n, lf;
    word_q_t w;
    w = {};
    build(0, AW_A, BASE_A, w, s, e, err);
    run_load(1'b0, s, 0, n, lf, ok);
    tests++;
    if (!ok || wq_a.size() != 0 || {done_a, error_a, cpu_hold_a} !== 3'b100) begin
      fails++; $display("FAIL zero_count: ok %0d writes %0d status %b want 1 0 100",
                        ok, wq_a.size(), {done_a, error_a, cpu_hold_a});
    end
    tests++;
    if (fall_a != lf + 1 || words_loaded_a !== 16'd0) begin
      fails++; $display("FAIL zero_count_timing: hold fell %0d words %0d want %0d 0",
                        fall_a, words_loaded_a, lf + 1);
    end
  endtask

  task automatic test_overflow;
    byte_q_t s;
    wr_q_t   e;
    bit      err, ok;
    int      n, lf;
    word_q_t w;
    s = {8'h00, 8'h11};
    run_load(1'b1, s, 0, n, lf, ok);
    tests++;
    if (!ok || {error_b, done_b, byte_ready_b, cpu_hold_b} !== 4'b1001 || wq_b.size() != 0) begin
      fails++; $display("FAIL overflow: ok %0d status %b writes %0d want 1 1001 0",
                        ok, {error_b, done_b, byte_ready_b, cpu_hold_b}, wq_b.size());
    end
    pulse_start(1'b1);
    tests++;
    if ({byte_ready_b, error_b} !== 2'b10) begin
      fails++; $display("FAIL overflow_recover: got %b want 10", {byte_ready_b, error_b});
    end
    // Exact-capacity image that wraps past the top of memory.
    w = {};
    for (int i = 0; i < 16; i++) w.push_back($urandom);
    build(16, AW_B, BASE_B, w, s, e, err);
    drive(1'b1, s, 2, n, lf);
    wait_end(1'b1, ok);
    tests++;
    if (!ok || wq_b.size() != 16 || done_b !== 1'b1 || words_loaded_b !== 16'd16) begin
      fails++; $display("FAIL full_fill: ok %0d writes %0d done %b words %0d want 1 16 1 16",
                        ok, wq_b.size(), done_b, words_loaded_b);
    end else begin
      bit bad = 1'b0;
      for (int i = 0; i < 16; i++) if (wq_b[i] !== e[i]) bad = 1'b1;
      tests++;
      if (bad) begin
        fails++; $display("FAIL full_fill_data: got first %h want %h", wq_b[0], e[0]);
      end
    end
  endtask

  task automatic test_valid_toggle;
    byte_q_t s;
    wr_q_t   e;
    bit      err, ok;
    int      n, lf;
    word_q_t w;
    w = {$urandom};
    build(1, AW_A, BASE_A, w, s, e, err);
    run_load(1'b0, s, 1, n, lf, ok);
    tests++;
    if (!ok || wq_a.size() != 1 || wq_a[0] !== e[0] || done_a !== 1'b1) begin
      fails++; $display("FAIL valid_toggle: writes %0d got %h want %h done %b", wq_a.size(),
                        (wq_a.size() > 0) ? wq_a[0] : 48'h0, e[0], done_a);
    end
  endtask

  task automatic test_reset_midload;
    byte_q_t s;
    wr_q_t   e;
    bit      err, ok;
    int      n, lf;
    word_q_t w;
    s = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wq_a = {};
    pulse_start(1'b0);
    drive(1'b0, s, 0, n, lf);
    tests++;
    if (n != 8 || words_loaded_a !== 16'd1) begin
      fails++; $display("FAIL pre_reset: consumed %0d words %0d want 8 1", n, words_loaded_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({wr_en_a, cpu_hold_a, byte_ready_a, done_a, error_a} !== 5'b01000 ||
        words_loaded_a !== 16'd0) begin
      fails++; $display("FAIL mid_reset: got %b words %0d want 01000 0",
                        {wr_en_a, cpu_hold_a, byte_ready_a, done_a, error_a}, words_loaded_a);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    w = {$urandom};
    build(1, AW_A, BASE_A, w, s, e, err);
    run_load(1'b0, s, 0, n, lf, ok);
    tests++;
    if (!ok || wq_a.size() != 1 || wq_a[0] !== {16'(BASE_A), w[0]}) begin
      fails++; $display("FAIL restart_load: writes %0d got %h want %h", wq_a.size(),
                        (wq_a.size() > 0) ? wq_a[0] : 48'h0, {16'(BASE_A), w[0]});
    end
  endtask

  task automatic test_back_to_back;
    byte_q_t s;
    wr_q_t   e, got;
    bit      err, ok, sel, bad;
    int      n, lf, count, fall;
    word_q_t w;
    logic    g_done, g_err, g_hold;
    logic [15:0] g_words;
    for (int it = 0; it < 10; it++) begin
      sel = 1'($urandom_range(0, 1));
      if (sel) count = $urandom_range(0, 17);
      else if ($urandom_range(0, 7) == 0) count = $urandom_range(257, 65535);
      else count = $urandom_range(0, 5);
      w = {};
      for (int i = 0; i < count && i < 20; i++) w.push_back($urandom);
      build(count, sel ? AW_B : AW_A, sel ? BASE_B : BASE_A, w, s, e, err);
      run_load(sel, s, 2, n, lf, ok);
      if (sel) begin
        got = wq_b; fall = fall_b; g_done = done_b; g_err = error_b;
        g_hold = cpu_hold_b; g_words = words_loaded_b;
      end else begin
        got = wq_a; fall = fall_a; g_done = done_a; g_err = error_a;
        g_hold = cpu_hold_a; g_words = words_loaded_a;
      end
      tests++;
      if (!ok || n != s.size() || {g_done, g_err, g_hold} !== {!err, err, err} ||
          g_words !== (err ? 16'd0 : 16'(count))) begin
        fails++; $display("FAIL load%0d_status: dut %0d count %0d ok %0d status %b words %0d want %b %0d",
                          it, sel, count, ok, {g_done, g_err, g_hold}, g_words,
                          {!err, err, err}, err ? 0 : count);
      end
      bad = (got.size() != e.size());
      for (int i = 0; i < got.size() && i < e.size(); i++) if (got[i] !== e[i]) bad = 1'b1;
      tests++;
      if (bad) begin
        fails++; $display("FAIL load%0d_writes: got %0d writes want %0d", it, got.size(), e.size());
      end
      if (!err) begin
        tests++;
        if (fall != lf + 1) begin
          fails++; $display("FAIL load%0d_release: hold fell %0d want %0d", it, fall, lf + 1);
        end
      end
    end
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_csum;
    byte_q_t s;
    bit      ok;
    int      n, lf;
    s = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
    run_load(1'b0, s, 0, n, lf, ok);
    tests++;
    if (!ok || {done_a, error_a} !== 2'b10 || wq_a.size() != 1 || wq_a[0] !== 48'h0000_AABBCCDD) begin
      fails++; $display("FAIL csum_good: status %b writes %0d want 10 1", {done_a, error_a}, wq_a.size());
    end
    s[6] = 8'h00;
    run_load(1'b0, s, 0, n, lf, ok);
    tests++;
    if (!ok || {done_a, error_a, cpu_hold_a} !== 3'b011 || wq_a.size() != 1 ||
        wq_a[0] !== 48'h0000_AABBCCDD) begin
      fails++; $display("FAIL csum_bad: status %b writes %0d want 011 1",
                        {done_a, error_a, cpu_hold_a}, wq_a.size());
    end
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_overflow();
    test_valid_toggle();
    test_reset_midload();
    test_back_to_back();
`ifdef IMEM_LOADER_CSUM_EN
    test_csum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
